// File: rtl/ff_xclk_sequencer_if.sv
// ff_xclk_sequencer_if: freeze/lock inputs and XCLK gate, camera reset and status outputs of ff_xclk_sequencer
interface ff_xclk_sequencer_if;
  logic ff_to_start;
  logic ff_done;
  logic lock;
  logic clr_err;
  logic xclk_en;
  logic cam_reset_n;
  logic ff_ready;
  logic lock_lost;
  logic [2:0] state;
  modport master (
    output ff_to_start, ff_done, lock, clr_err,
    input xclk_en, cam_reset_n, ff_ready, lock_lost, state
  );
  modport slave (
    input ff_to_start, ff_done, lock, clr_err,
    output xclk_en, cam_reset_n, ff_ready, lock_lost, state
  );
endinterface

// File: rtl/ff_xclk_sequencer.sv
// ff_xclk_sequencer: gates camera XCLK and holds CAM_RESET_N around PLL lock and Flash*Freeze; ports clk_base, reset (sync, active high), bus (slave: ff_to_start/ff_done/lock/clr_err in, xclk_en/cam_reset_n/ff_ready/lock_lost/state out)
module ff_xclk_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int CAM_RST_CYC = 256,
  parameter int DRAIN_CYC = 16,
  parameter int CNT_W = 16
) (
  input logic clk_base,
  input logic reset,
  ff_xclk_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    CAM_RST = 3'd1,
    RUN = 3'd2,
    DRAIN = 3'd3,
    FROZEN = 3'd4
  } state_t;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CAM_LAST = CNT_W'(CAM_RST_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
  logic [SYNC_STAGES-1:0] lock_sh, start_sh, done_sh;
  logic lock_s, start_s, done_s;
  logic [2:0] state_q;
  state_t state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic set_lost;
  logic xclk_q, cam_q, ready_q, lost_q;
  assign lock_s = lock_sh[SYNC_STAGES-1];
  assign start_s = start_sh[SYNC_STAGES-1];
  assign done_s = done_sh[SYNC_STAGES-1];
  assign bus.xclk_en = xclk_q;
  assign bus.cam_reset_n = cam_q;
  assign bus.ff_ready = ready_q;
  assign bus.lock_lost = lost_q;
  assign bus.state = state_q;
  always_ff @(posedge clk_base) begin
    if (reset) begin
      lock_sh <= '0;
      start_sh <= '0;
      done_sh <= '0;
      state_q <= WAIT_LOCK;
      cnt_q <= '0;
      xclk_q <= 1'b0;
      cam_q <= 1'b0;
      ready_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      lock_sh <= {lock_sh[SYNC_STAGES-2:0], bus.lock};
      start_sh <= {start_sh[SYNC_STAGES-2:0], bus.ff_to_start};
      done_sh <= {done_sh[SYNC_STAGES-2:0], bus.ff_done};
      state_q <= state_d;
      cnt_q <= cnt_d;
      xclk_q <= state_d inside {CAM_RST, RUN, DRAIN};
      cam_q <= state_d inside {RUN, DRAIN};
      ready_q <= state_d == FROZEN;
      lost_q <= set_lost | (lost_q & ~bus.clr_err);
    end
  end
  always_comb begin
    state_d = WAIT_LOCK;
    cnt_d = '0;
    set_lost = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        state_d = start_s ? FROZEN : (lock_s && cnt_q == LOCK_LAST) ? CAM_RST : WAIT_LOCK;
        cnt_d = (!start_s && lock_s && cnt_q != LOCK_LAST) ? cnt_q + 1'b1 : '0;
      end
      CAM_RST: begin
        state_d = start_s ? DRAIN : !lock_s ? WAIT_LOCK : (cnt_q == CAM_LAST) ? RUN : CAM_RST;
        set_lost = !start_s && !lock_s;
        cnt_d = (state_d == CAM_RST) ? cnt_q + 1'b1 : '0;
      end
      RUN: begin
        state_d = start_s ? DRAIN : lock_s ? RUN : WAIT_LOCK;
        set_lost = !start_s && !lock_s;
      end
      DRAIN: begin
        state_d = !start_s ? RUN : (cnt_q == DRAIN_LAST) ? FROZEN : DRAIN;
        set_lost = !lock_s;
        cnt_d = (state_d == DRAIN) ? cnt_q + 1'b1 : '0;
      end
      FROZEN: state_d = (start_s || done_s) ? FROZEN : WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end
endmodule

// File: tb/tb_ff_xclk_sequencer.sv
// tb_ff_xclk_sequencer: scoreboard bench for ff_xclk_sequencer against a dwell-count reference model
module tb_ff_xclk_sequencer;
  localparam int SS = 2;
  localparam int LSC = 8;
  localparam int CRC = 4;
  localparam int DC = 3;
  logic clk_base = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  time skip_t = 0;
  logic [6:0] exp_q[$];
  ff_xclk_sequencer_if bus();
  ff_xclk_sequencer #(
    .SYNC_STAGES(SS),
    .LOCK_STABLE_CYC(LSC),
    .CAM_RST_CYC(CRC),
    .DRAIN_CYC(DC),
    .CNT_W(16)
  ) dut (
    .clk_base(clk_base),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk_base = ~clk_base;
  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask
  int m_st = 0;
  int m_cnt = 0;
  bit m_lost = 1'b0;
  bit [SS-1:0] h_lock = '0, h_start = '0, h_done = '0;
  always @(posedge clk_base) begin : model
    bit l, s, d, set;
    int n;
    l = h_lock[SS-1];
    s = h_start[SS-1];
    d = h_done[SS-1];
    set = 1'b0;
    if (reset) begin
      m_st = 0;
      m_cnt = 0;
      m_lost = 1'b0;
      h_lock = '0;
      h_start = '0;
      h_done = '0;
    end else begin
      n = m_st;
      case (m_st)
        0: if (s) n = 4;
           else if (!l) m_cnt = 0;
           else begin m_cnt++; if (m_cnt == LSC) n = 1; end
        1: if (s) n = 3;
           else if (!l) begin n = 0; set = 1'b1; end
           else begin m_cnt++; if (m_cnt == CRC) n = 2; end
        2: if (s) n = 3;
           else if (!l) begin n = 0; set = 1'b1; end
        3: begin
             set = !l;
             if (!s) n = 2;
             else begin m_cnt++; if (m_cnt == DC) n = 4; end
           end
        4: if (!s && !d) n = 0;
        default: n = 0;
      endcase
      if (n != m_st) m_cnt = 0;
      m_st = n;
      m_lost = set | (m_lost & ~bus.clr_err);
      h_lock = {h_lock[SS-2:0], bus.lock};
      h_start = {h_start[SS-2:0], bus.ff_to_start};
      h_done = {h_done[SS-2:0], bus.ff_done};
    end
    exp_q.push_back({3'(m_st), m_st inside {1, 2, 3}, m_st inside {2, 3}, m_st == 4, m_lost});
  end
  initial forever begin : monitor
    logic [6:0] e, a;
    @(negedge clk_base);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {bus.state, bus.xclk_en, bus.cam_reset_n, bus.ff_ready, bus.lock_lost};
      if ($time != skip_t) check("scoreboard {state,xclk,camn,ready,lost}", int'(a), int'(e));
    end
  end
  task automatic tick(input int c);
    repeat (c) @(negedge clk_base);
  endtask
  task automatic wait_state(input logic [2:0] st, input int lim, output int n);
    n = 0;
    do begin @(negedge clk_base); n++; end while (bus.state !== st && n < lim);
  endtask
  task automatic wait_xclk(input logic v, input int lim, output int n);
    n = 0;
    do begin @(negedge clk_base); n++; end while (bus.xclk_en !== v && n < lim);
  endtask
  initial begin : stim
    int n;
    bit xdrop, rdy, saw_drain;
    bus.lock = 1'b1;
    bus.ff_to_start = 1'b0;
    bus.ff_done = 1'b0;
    bus.clr_err = 1'b0;
    tick(3);
    check("reset_outputs", int'({bus.state, bus.xclk_en, bus.cam_reset_n, bus.ff_ready, bus.lock_lost}), 0);
    reset = 1'b0;
    wait_xclk(1'b1, 64, n);
    check("pwrup_xclk_latency", n, SS + LSC);
    check("pwrup_state_cam_rst", int'(bus.state), 1);
    wait_state(3'd2, 64, n);
    check("pwrup_camn_delay", n, CRC);
    check("pwrup_camn_high", int'(bus.cam_reset_n), 1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(7);
    bus.lock = 1'b0;
    tick(1);
    bus.lock = 1'b1;
    wait_xclk(1'b1, 64, n);
    check("glitch_xclk_latency", n, SS + LSC);
    wait_state(3'd2, 64, n);
    check("glitch_run", int'(bus.state), 2);
    bus.ff_to_start = 1'b1;
    wait_state(3'd3, 16, n);
    check("drain_entry_latency", n, SS + 1);
    wait_state(3'd4, 16, n);
    check("drain_length", n, DC);
    check("frozen_outputs {xclk,camn,ready}", int'({bus.xclk_en, bus.cam_reset_n, bus.ff_ready}), 1);
    bus.ff_done = 1'b1;
    bus.ff_to_start = 1'b0;
    tick(6);
    check("frozen_hold_on_done", int'(bus.state), 4);
    bus.ff_done = 1'b0;
    wait_state(3'd0, 16, n);
    check("thaw_latency", n, SS + 1);
    wait_state(3'd2, 64, n);
    check("relock_run", int'(bus.state), 2);
    bus.ff_to_start = 1'b1;
    tick(2);
    bus.ff_to_start = 1'b0;
    xdrop = 1'b0;
    rdy = 1'b0;
    saw_drain = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_base);
      if (bus.xclk_en !== 1'b1) xdrop = 1'b1;
      if (bus.ff_ready !== 1'b0) rdy = 1'b1;
      if (bus.state === 3'd3) saw_drain = 1'b1;
    end
    check("abort_saw_drain", int'(saw_drain), 1);
    check("abort_xclk_drop", int'(xdrop), 0);
    check("abort_ff_ready", int'(rdy), 0);
    check("abort_back_to_run", int'(bus.state), 2);
    bus.lock = 1'b0;
    wait_xclk(1'b0, 16, n);
    check("lockloss_latency", n, SS + 1);
    check("lockloss_sticky", int'(bus.lock_lost), 1);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("clr_err_clears", int'(bus.lock_lost), 0);
    bus.lock = 1'b1;
    wait_state(3'd2, 64, n);
    check("relock_after_loss", int'(bus.state), 2);
    bus.lock = 1'b0;
    tick(2);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("set_beats_clr", int'(bus.lock_lost), 1);
    bus.lock = 1'b1;
    wait_state(3'd1, 64, n);
    check("reach_cam_rst", int'(bus.state), 1);
    reset = 1'b1;
    tick(1);
    check("reset_in_cam_rst", int'({bus.state, bus.xclk_en, bus.cam_reset_n, bus.ff_ready, bus.lock_lost}), 0);
    reset = 1'b0;
    bus.ff_to_start = 1'b1;
    wait_state(3'd4, 16, n);
    check("reach_frozen", int'(bus.state), 4);
    reset = 1'b1;
    tick(1);
    check("reset_in_frozen", int'({bus.state, bus.xclk_en, bus.cam_reset_n, bus.ff_ready, bus.lock_lost}), 0);
    reset = 1'b0;
    bus.ff_to_start = 1'b0;
    bus.lock = 1'b0;
    tick(4);
    @(posedge clk_base);
    #1 force dut.state_q = 3'd6;
    #1 release dut.state_q;
    skip_t = $time + 3;
    tick(2);
    check("illegal_state_recovers", int'(bus.state), 0);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_base);
      bus.clr_err = ($urandom_range(0, 19) == 0);
      if (bus.lock) bus.lock = ($urandom_range(0, 99) >= 2);
      else bus.lock = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 39) == 0) bus.ff_to_start = ~bus.ff_to_start;
      if ($urandom_range(0, 39) == 0) bus.ff_done = ~bus.ff_done;
      reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk_base);
    reset = 1'b0;
    bus.clr_err = 1'b0;
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
